sifive_scope_dcache_tracker: RTL and testbench
==============================================

# sifive_scope_dcache_tracker

Downstream consumer of the hart-0 DCache scope probe. Pairs each commit-stage DCache request event with its later response event by tag, measures request-to-response latency in cycles, and emits one completed-transaction record per pair through a small output FIFO with a valid/ready handshake. Flags protocol anomalies (duplicate tags, orphan responses) and counts records lost to back-pressure. Used by trace and performance-monitor logic fed from the scope.

## Interface
Parameters:
- TAG_W, 3, request tag width; table holds 2^TAG_W entries, indexed by tag
- ADDR_W, 32, request address width
- LAT_W, 16, latency field width
- FIFO_DEPTH, 4, output record FIFO depth (power of two, >= 2)

Ports:
- clock  in  1  clock; single clock domain
- reset  in  1  asynchronous, active-high reset
- req_valid  in  1  scope request event this cycle
- req_tag  in  TAG_W  request tag
- req_addr  in  ADDR_W  request address
- req_cmd  in  5  memory command code
- req_size  in  2  log2 access size
- resp_valid  in  1  scope response event this cycle
- resp_tag  in  TAG_W  tag of the request being answered
- resp_has_data  in  1  response carries load data
- out_valid  out  1  record available
- out_ready  in  1  consumer accepts record
- out_addr  out  ADDR_W  record address
- out_cmd  out  5  record command
- out_size  out  2  record size
- out_has_data  out  1  record has_data flag
- out_latency  out  LAT_W  response cycle minus request cycle, modulo 2^LAT_W
- outstanding  out  TAG_W+1  count of valid table entries
- err_dup_tag  out  1  sticky: request hit an already-valid tag
- err_orphan_resp  out  1  sticky: response hit an invalid tag
- drop_count  out  8  saturating count of records dropped on FIFO full

## Operation
- Free-running LAT_W-bit cycle counter `now`, wraps.
- Table entry per tag: valid, addr, cmd, size, stamp.
- Request: entry[req_tag] <= {1, addr, cmd, size, now}. If the entry was already valid (after same-cycle response processing), set err_dup_tag; new request overwrites the old one (old one is never reported).
- Response: if entry[resp_tag] valid, build record {addr, cmd, size, resp_has_data, now - stamp}, clear the entry, and push the record. If invalid, set err_orphan_resp; no push.
- Same cycle, same tag, request and response: response is processed first against the existing entry, then the request allocates. No dup error unless the entry stayed valid, which cannot happen; no orphan error if the entry was valid.
- Same cycle, different tags: both processed independently.
- FIFO push when full and no pop this cycle: record dropped, drop_count += 1, saturating at 255; the table entry is still freed.
- Push while full with a pop in the same cycle: push accepted.
- Pop on out_valid && out_ready. Output fields come from the FIFO head and are stable while out_valid && !out_ready.
- outstanding = number of valid entries, updated at the same edge as the table.
- Sticky error flags clear only on reset.

## Timing
- Reset (async assert, released synchronously by the clock domain): all entries invalid, `now`=0, FIFO empty, out_valid=0, all out_* data=0, outstanding=0, err flags=0, drop_count=0.
- Reset asserted mid-operation discards all entries and queued records immediately; nothing is emitted afterward for pre-reset requests.
- Request at cycle t, response at cycle t+k: out_latency=k (mod 2^LAT_W); minimum reportable k is 1.
- Response at cycle t with an empty FIFO: out_valid=1 in cycle t+1.
- Throughput: one record per cycle, sustained with out_ready=1.
- Error flags and drop_count update at the edge ending the cycle of the offending event; they are visible in the next cycle.

## Test plan
- Reset, then request tag 2 addr 0x8000_0040 cmd 0 size 3 at cycle 10, response tag 2 has_data=1 at cycle 17 -> one record at cycle 18: addr 0x8000_0040, latency 7, has_data 1. outstanding is 1 during cycles 11-17 and 0 from cycle 18.
- Requests on tags 0-7 on consecutive cycles, responses in reverse order with out_ready=1 -> 8 records in response order with correct per-tag latencies. outstanding peaks at 8. No error flags set.
- Request tag 5 followed by a second request tag 5 -> err_dup_tag=1. A later response tag 5 reports the second request's addr and latency.
- Response tag 3 with no prior request -> err_orphan_resp=1, no record, out_valid stays 0. In the same cycle, request+response on a valid tag 1 -> old entry reported and new entry allocated.
- out_ready=0 with 6 completed pairs and FIFO_DEPTH=4 -> 4 records held, drop_count=2. Then out_ready=1 with a simultaneous push -> push accepted, drop_count stays 2.
- Request at cycle 0, response 70000 cycles later with LAT_W=16 -> out_latency = 70000 mod 65536 = 4464. Assert reset with 3 entries valid and 2 records queued -> outstanding=0 and out_valid=0 immediately.

Source files
------------

// File: rtl/sifive_scope_dcache_tracker.sv
// Pairs DCache scope request/response events by tag, measures their latency in cycles,
// and queues one completed-transaction record per pair in a small output FIFO.
module sifive_scope_dcache_tracker #(
  parameter int TAG_W      = 3,
  parameter int ADDR_W     = 32,
  parameter int LAT_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [TAG_W-1:0]  req_tag,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [4:0]        req_cmd,
  input  logic [1:0]        req_size,
  input  logic              resp_valid,
  input  logic [TAG_W-1:0]  resp_tag,
  input  logic              resp_has_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [4:0]        out_cmd,
  output logic [1:0]        out_size,
  output logic              out_has_data,
  output logic [LAT_W-1:0]  out_latency,
  output logic [TAG_W:0]    outstanding,
  output logic              err_dup_tag,
  output logic              err_orphan_resp,
  output logic [7:0]        drop_count
);
  localparam int ENTRIES = 1 << TAG_W;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int REC_W   = ADDR_W + 5 + 2 + 1 + LAT_W;

  logic [LAT_W-1:0]  now;
  logic [ENTRIES-1:0] ent_valid;
  logic [ENTRIES-1:0] ent_valid_nxt;
  logic [ADDR_W-1:0] ent_addr  [ENTRIES];
  logic [4:0]        ent_cmd   [ENTRIES];
  logic [1:0]        ent_size  [ENTRIES];
  logic [LAT_W-1:0]  ent_stamp [ENTRIES];

  logic              resp_hit;
  logic              orphan;
  logic              dup;
  logic              pop;
  logic              full;
  logic              accept;
  logic              drop;
  logic [REC_W-1:0]  rec;
  logic [REC_W-1:0]  head;
  logic [TAG_W:0]    valid_cnt_nxt;

  logic [REC_W-1:0]  fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W:0]    fifo_cnt;

  // The response is resolved against the table first, so a same-tag request in
  // the same cycle sees a freed entry and never raises the duplicate flag.
  always_comb begin
    resp_hit      = resp_valid && ent_valid[resp_tag];
    orphan        = resp_valid && !ent_valid[resp_tag];
    ent_valid_nxt = ent_valid;
    if (resp_hit) ent_valid_nxt[resp_tag] = 1'b0;
    dup = req_valid && ent_valid_nxt[req_tag];
    if (req_valid) ent_valid_nxt[req_tag] = 1'b1;
    rec = {ent_addr[resp_tag], ent_cmd[resp_tag], ent_size[resp_tag], resp_has_data,
           now - ent_stamp[resp_tag]};
  end

  always_comb begin
    valid_cnt_nxt = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      valid_cnt_nxt = valid_cnt_nxt + {{TAG_W{1'b0}}, ent_valid_nxt[i]};
    end
  end

  // Handshake: a record transfers on a cycle where out_valid && out_ready; while
  // out_valid is high and out_ready is low the head record is held unchanged.
  always_comb begin
    out_valid = (fifo_cnt != '0);
    full      = (fifo_cnt == (PTR_W + 1)'(FIFO_DEPTH));
    pop       = out_valid && out_ready;
    accept    = resp_hit && (!full || pop);
    drop      = resp_hit && full && !pop;
    head      = out_valid ? fifo_mem[rd_ptr] : '0;
    {out_addr, out_cmd, out_size, out_has_data, out_latency} = head;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      now             <= '0;
      ent_valid       <= '0;
      outstanding     <= '0;
      err_dup_tag     <= 1'b0;
      err_orphan_resp <= 1'b0;
      drop_count      <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fifo_cnt        <= '0;
    end else begin
      now         <= now + LAT_W'(1);
      ent_valid   <= ent_valid_nxt;
      outstanding <= valid_cnt_nxt;
      if (dup) err_dup_tag <= 1'b1;
      if (orphan) err_orphan_resp <= 1'b1;
      if (drop && drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      if (accept) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (accept && !pop) fifo_cnt <= fifo_cnt + (PTR_W + 1)'(1);
      else if (pop && !accept) fifo_cnt <= fifo_cnt - (PTR_W + 1)'(1);
    end
  end

  // Payload storage needs no reset: validity lives in ent_valid and fifo_cnt.
  always_ff @(posedge clock) begin
    if (req_valid) begin
      ent_addr[req_tag]  <= req_addr;
      ent_cmd[req_tag]   <= req_cmd;
      ent_size[req_tag]  <= req_size;
      ent_stamp[req_tag] <= now;
    end
    if (accept) fifo_mem[wr_ptr] <= rec;
  end
endmodule

// File: tb/tb_sifive_scope_dcache_tracker.sv
// Scenario bench for the DCache scope tracker: each task drives one feature and checks
// DUT outputs against explicit values and a transaction-level reference model.
module tb_sifive_scope_dcache_tracker;
  localparam int TAG_W      = 3;
  localparam int ADDR_W     = 32;
  localparam int LAT_W      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int ENTRIES    = 1 << TAG_W;
  localparam int REC_W      = ADDR_W + 5 + 2 + 1 + LAT_W;

  // clock / reset
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  logic              req_valid = 1'b0;
  logic [TAG_W-1:0]  req_tag = '0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [4:0]        req_cmd = '0;
  logic [1:0]        req_size = '0;
  logic              resp_valid = 1'b0;
  logic [TAG_W-1:0]  resp_tag = '0;
  logic              resp_has_data = 1'b0;
  logic              out_ready = 1'b0;
  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic [4:0]        out_cmd;
  logic [1:0]        out_size;
  logic              out_has_data;
  logic [LAT_W-1:0]  out_latency;
  logic [TAG_W:0]    outstanding;
  logic              err_dup_tag;
  logic              err_orphan_resp;
  logic [7:0]        drop_count;

  sifive_scope_dcache_tracker #(
    .TAG_W(TAG_W), .ADDR_W(ADDR_W), .LAT_W(LAT_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_tag(req_tag), .req_addr(req_addr),
    .req_cmd(req_cmd), .req_size(req_size),
    .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_has_data(resp_has_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_cmd(out_cmd), .out_size(out_size),
    .out_has_data(out_has_data), .out_latency(out_latency),
    .outstanding(outstanding), .err_dup_tag(err_dup_tag),
    .err_orphan_resp(err_orphan_resp), .drop_count(drop_count)
  );

  int total = 0;
  int bad   = 0;

  // reference model: tag table, record queue, sticky flags, drop counter
  int                tb_now;
  logic [REC_W-1:0]  exp_q[$];
  bit                m_valid [ENTRIES];
  logic [ADDR_W-1:0] m_addr  [ENTRIES];
  logic [4:0]        m_cmd   [ENTRIES];
  logic [1:0]        m_size  [ENTRIES];
  int                m_stamp [ENTRIES];
  bit                m_dup;
  bit                m_orphan;
  int                m_drops;

  function automatic int m_outstanding();
    int n = 0;
    for (int i = 0; i < ENTRIES; i++) n += m_valid[i];
    return n;
  endfunction

  function automatic logic [REC_W-1:0] dut_rec();
    return {out_addr, out_cmd, out_size, out_has_data, out_latency};
  endfunction

  function automatic logic [REC_W-1:0] exp_head();
    return (exp_q.size() != 0) ? exp_q[0] : '0;
  endfunction

  // driver tasks
  task automatic idle_inputs();
    req_valid  = 1'b0;
    resp_valid = 1'b0;
  endtask

  task automatic set_req(input int tag, input logic [ADDR_W-1:0] addr,
                         input logic [4:0] cmd, input logic [1:0] size);
    req_valid = 1'b1;
    req_tag   = TAG_W'(tag);
    req_addr  = addr;
    req_cmd   = cmd;
    req_size  = size;
  endtask

  task automatic set_resp(input int tag, input logic has_data);
    resp_valid    = 1'b1;
    resp_tag      = TAG_W'(tag);
    resp_has_data = has_data;
  endtask

  // Applies the current cycle's events to the model, then advances one clock.
  task automatic tick();
    logic [REC_W-1:0] rec;
    bit hit;
    bit popd;
    rec  = '0;
    hit  = resp_valid && m_valid[resp_tag];
    popd = (exp_q.size() != 0) && out_ready;
    if (resp_valid && !m_valid[resp_tag]) m_orphan = 1'b1;
    if (hit) begin
      rec = {m_addr[resp_tag], m_cmd[resp_tag], m_size[resp_tag], resp_has_data,
             LAT_W'(tb_now - m_stamp[resp_tag])};
      m_valid[resp_tag] = 1'b0;
    end
    if (req_valid) begin
      if (m_valid[req_tag]) m_dup = 1'b1;
      m_valid[req_tag] = 1'b1;
      m_addr[req_tag]  = req_addr;
      m_cmd[req_tag]   = req_cmd;
      m_size[req_tag]  = req_size;
      m_stamp[req_tag] = tb_now;
    end
    if (popd) void'(exp_q.pop_front());
    if (hit) begin
      if (exp_q.size() < FIFO_DEPTH) exp_q.push_back(rec);
      else if (m_drops < 255) m_drops++;
    end
    @(posedge clock);
    #1;
    tb_now++;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    out_ready = 1'b0;
    exp_q.delete();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    m_dup = 1'b0;
    m_orphan = 1'b0;
    m_drops = 0;
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    tb_now = 0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (out_valid !== 1'b0 || outstanding !== '0) begin
      bad++;
      $display("FAIL reset_valid: got out_valid=%b outstanding=%0d need 0/0", out_valid, outstanding);
    end
    total++;
    if (dut_rec() !== '0) begin
      bad++;
      $display("FAIL reset_data: got %h need 0", dut_rec());
    end
    total++;
    if (err_dup_tag !== 1'b0 || err_orphan_resp !== 1'b0 || drop_count !== 8'd0) begin
      bad++;
      $display("FAIL reset_flags: got dup=%b orphan=%b drops=%0d need 0/0/0",
               err_dup_tag, err_orphan_resp, drop_count);
    end
  endtask

  task automatic test_single();
    repeat (10) tick();
    set_req(2, 32'h8000_0040, 5'd0, 2'd3);
    tick();
    idle_inputs();
    for (int c = 0; c < 7; c++) begin
      total++;
      if (outstanding !== 4'd1) begin
        bad++;
        $display("FAIL single_outstanding: cycle %0d got %0d need 1", c, outstanding);
      end
      if (c == 6) set_resp(2, 1'b1);
      tick();
      idle_inputs();
    end
    total++;
    if (out_valid !== 1'b1 || dut_rec() !== {32'h8000_0040, 5'd0, 2'd3, 1'b1, 16'd7}) begin
      bad++;
      $display("FAIL single_record: got valid=%b rec=%h need 1 rec=%h", out_valid, dut_rec(),
               {32'h8000_0040, 5'd0, 2'd3, 1'b1, 16'd7});
    end
    total++;
    if (outstanding !== 4'd0) begin
      bad++;
      $display("FAIL single_freed: got outstanding=%0d need 0", outstanding);
    end
    out_ready = 1'b1;
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL single_pop: got out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_reverse();
    logic [ADDR_W-1:0] a [ENTRIES];
    int tag;
    out_ready = 1'b1;
    for (int i = 0; i < ENTRIES; i++) begin
      a[i] = $urandom();
      set_req(i, a[i], 5'(i), 2'(i));
      tick();
    end
    idle_inputs();
    total++;
    if (outstanding !== 4'd8) begin
      bad++;
      $display("FAIL reverse_peak: got outstanding=%0d need 8", outstanding);
    end
    for (int j = 0; j < ENTRIES; j++) begin
      tag = ENTRIES - 1 - j;
      set_resp(tag, 1'(j));
      tick();
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || dut_rec() !== {a[tag], 5'(tag), 2'(tag), 1'(j), 16'(15 - 2 * tag)}) begin
        bad++;
        $display("FAIL reverse_record: tag %0d got valid=%b rec=%h need rec=%h", tag, out_valid,
                 dut_rec(), {a[tag], 5'(tag), 2'(tag), 1'(j), 16'(15 - 2 * tag)});
      end
    end
    tick();
    total++;
    if (out_valid !== 1'b0 || err_dup_tag !== 1'b0 || err_orphan_resp !== 1'b0) begin
      bad++;
      $display("FAIL reverse_clean: got valid=%b dup=%b orphan=%b need 0/0/0",
               out_valid, err_dup_tag, err_orphan_resp);
    end
  endtask

  task automatic test_dup();
    out_ready = 1'b1;
    set_req(5, 32'hAAAA_0000, 5'd1, 2'd0);
    tick();
    set_req(5, 32'hBBBB_0004, 5'd2, 2'd1);
    tick();
    idle_inputs();
    total++;
    if (err_dup_tag !== 1'b1) begin
      bad++;
      $display("FAIL dup_flag: got %b need 1", err_dup_tag);
    end
    tick();
    tick();
    set_resp(5, 1'b0);
    tick();
    idle_inputs();
    total++;
    if (out_valid !== 1'b1 || dut_rec() !== {32'hBBBB_0004, 5'd2, 2'd1, 1'b0, 16'd3}) begin
      bad++;
      $display("FAIL dup_record: got valid=%b rec=%h need rec=%h", out_valid, dut_rec(),
               {32'hBBBB_0004, 5'd2, 2'd1, 1'b0, 16'd3});
    end
    tick();
  endtask

  task automatic test_orphan();
    do_reset();
    out_ready = 1'b1;
    set_resp(3, 1'b1);
    tick();
    idle_inputs();
    total++;
    if (err_orphan_resp !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL orphan_flag: got orphan=%b valid=%b need 1/0", err_orphan_resp, out_valid);
    end
    set_req(1, 32'hC000_0010, 5'd3, 2'd2);
    tick();
    idle_inputs();
    tick();
    set_req(1, 32'hD000_0020, 5'd4, 2'd1);
    set_resp(1, 1'b1);
    tick();
    idle_inputs();
    total++;
    if (out_valid !== 1'b1 || dut_rec() !== {32'hC000_0010, 5'd3, 2'd2, 1'b1, 16'd2}) begin
      bad++;
      $display("FAIL same_cycle_record: got valid=%b rec=%h need rec=%h", out_valid, dut_rec(),
               {32'hC000_0010, 5'd3, 2'd2, 1'b1, 16'd2});
    end
    total++;
    if (outstanding !== 4'd1 || err_dup_tag !== 1'b0) begin
      bad++;
      $display("FAIL same_cycle_alloc: got outstanding=%0d dup=%b need 1/0", outstanding, err_dup_tag);
    end
    set_resp(1, 1'b0);
    tick();
    idle_inputs();
    total++;
    if (out_valid !== 1'b1 || dut_rec() !== {32'hD000_0020, 5'd4, 2'd1, 1'b0, 16'd1}) begin
      bad++;
      $display("FAIL same_cycle_new: got valid=%b rec=%h need rec=%h", out_valid, dut_rec(),
               {32'hD000_0020, 5'd4, 2'd1, 1'b0, 16'd1});
    end
    tick();
  endtask

  task automatic test_backpressure();
    logic [ADDR_W-1:0] a [ENTRIES];
    int order [4] = '{1, 2, 3, 6};
    do_reset();
    out_ready = 1'b0;
    for (int t = 0; t < 7; t++) begin
      a[t] = 32'h1000_0000 + 32'(t * 64);
      set_req(t, a[t], 5'd1, 2'd2);
      tick();
    end
    idle_inputs();
    for (int t = 0; t < 6; t++) begin
      set_resp(t, 1'b1);
      tick();
    end
    idle_inputs();
    tick();
    total++;
    if (drop_count !== 8'd2 || out_valid !== 1'b1 || out_addr !== a[0]) begin
      bad++;
      $display("FAIL bp_hold: got drops=%0d valid=%b addr=%h need 2/1/%h",
               drop_count, out_valid, out_addr, a[0]);
    end
    out_ready = 1'b1;
    set_resp(6, 1'b0);
    for (int k = 0; k < 4; k++) begin
      tick();
      idle_inputs();
      total++;
      if (out_valid !== 1'b1 || out_addr !== a[order[k]] || dut_rec() !== exp_head()) begin
        bad++;
        $display("FAIL bp_drain: step %0d got valid=%b rec=%h need addr=%h rec=%h",
                 k, out_valid, dut_rec(), a[order[k]], exp_head());
      end
    end
    total++;
    if (drop_count !== 8'd2) begin
      bad++;
      $display("FAIL bp_full_pop_push: got drops=%0d need 2", drop_count);
    end
    tick();
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL bp_empty: got out_valid=%b need 0", out_valid);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      idle_inputs();
      if ($urandom_range(0, 2) != 0)
        set_req($urandom_range(0, ENTRIES - 1), $urandom(), 5'($urandom_range(0, 31)),
                2'($urandom_range(0, 3)));
      if ($urandom_range(0, 2) != 0)
        set_resp($urandom_range(0, ENTRIES - 1), 1'($urandom_range(0, 1)));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
      total++;
      if (out_valid !== (exp_q.size() != 0) || (out_valid && dut_rec() !== exp_head())) begin
        bad++;
        $display("FAIL rand_record: cycle %0d got valid=%b rec=%h need valid=%b rec=%h",
                 c, out_valid, dut_rec(), exp_q.size() != 0, exp_head());
      end
      total++;
      if (outstanding !== (TAG_W + 1)'(m_outstanding())) begin
        bad++;
        $display("FAIL rand_outstanding: cycle %0d got %0d need %0d", c, outstanding, m_outstanding());
      end
      total++;
      if (err_dup_tag !== m_dup || err_orphan_resp !== m_orphan || drop_count !== 8'(m_drops)) begin
        bad++;
        $display("FAIL rand_status: cycle %0d got dup=%b orphan=%b drops=%0d need %b/%b/%0d",
                 c, err_dup_tag, err_orphan_resp, drop_count, m_dup, m_orphan, m_drops);
      end
    end
    idle_inputs();
  endtask

  task automatic test_wrap_and_reset();
    do_reset();
    out_ready = 1'b0;
    set_req(0, 32'h1234_5678, 5'd3, 2'd0);
    tick();
    idle_inputs();
    repeat (69999) tick();
    set_resp(0, 1'b1);
    tick();
    idle_inputs();
    total++;
    if (out_valid !== 1'b1 || out_latency !== 16'd4464) begin
      bad++;
      $display("FAIL latency_wrap: got valid=%b latency=%0d need 1/4464", out_valid, out_latency);
    end
    set_req(4, 32'h4444_0000, 5'd0, 2'd0);
    tick();
    set_resp(4, 1'b0);
    idle_inputs();
    set_resp(4, 1'b0);
    tick();
    idle_inputs();
    for (int t = 1; t <= 3; t++) begin
      set_req(t, 32'(t), 5'd0, 2'd0);
      tick();
    end
    idle_inputs();
    total++;
    if (outstanding !== 4'd3 || exp_q.size() != 2 || out_valid !== 1'b1) begin
      bad++;
      $display("FAIL pre_reset_state: got outstanding=%0d valid=%b need 3/1", outstanding, out_valid);
    end
    #2;
    reset = 1'b1;
    #1;
    total++;
    if (outstanding !== '0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL async_reset: got outstanding=%0d valid=%b need 0/0", outstanding, out_valid);
    end
    do_reset();
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (out_valid !== 1'b0 || outstanding !== '0) begin
        bad++;
        $display("FAIL post_reset_quiet: cycle %0d got valid=%b outstanding=%0d need 0/0",
                 c, out_valid, outstanding);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_reverse();
    test_dup();
    test_orphan();
    test_backpressure();
    test_random();
    test_wrap_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
